// File: rtl/clk_cfg_pkg.sv
// Shared types and field positions for the APB clock-configuration bridge
// and its lock monitors.
package clk_cfg_pkg;

    typedef enum logic [1:0] {
        CH_SOC     = 2'd0,
        CH_PER     = 2'd1,
        CH_CLUSTER = 2'd2,
        CH_STATUS  = 2'd3
    } channel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int NUM_CH          = 3;
    localparam int CFG_ADD_W       = 5;
    localparam int CFG_DATA_W      = 32;
    localparam int STATUS_LOCK_LSB = 0;
    localparam int STATUS_LOST_LSB = 8;

    function automatic logic [CFG_DATA_W-1:0] status_word(
        input logic [NUM_CH-1:0] locks,
        input logic [NUM_CH-1:0] lost
    );
        logic [CFG_DATA_W-1:0] w;
        w = '0;
        w[STATUS_LOCK_LSB +: NUM_CH] = locks;
        w[STATUS_LOST_LSB +: NUM_CH] = lost;
        return w;
    endfunction

endpackage

// File: rtl/clk_cfg_lock_mon.sv
// Lock monitor for one clock channel: 2-flop synchroniser, falling-edge
// detect and a sticky lock-lost flag with write-1-to-clear.
module clk_cfg_lock_mon (
    input  logic clk,
    input  logic rst_n,
    input  logic lock_async,
    input  logic clr,
    output logic lock_sync,
    output logic lost
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic lost_q;
    logic fall;

    assign fall = prev_q & ~sync_q;

    // A fall in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            meta_q <= lock_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
            lost_q <= fall | (lost_q & ~clr);
        end
    end

    assign lock_sync = sync_q;
    assign lost      = lost_q;

endmodule

// File: rtl/apb_clk_cfg_if.sv
// APB slave bridging bus accesses onto the soc/per/cluster clock-generator
// config handshakes; optional ack timeout enabled by CLK_CFG_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for an APB access; status accesses complete here
// REQ     | selected channel req high, waiting for ack (or timeout)
// RESP    | pready for one cycle with captured read data / error
module apb_clk_cfg_if
    import clk_cfg_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,

    output logic                      soc_cfg_req_o,
    input  logic                      soc_cfg_ack_i,
    output logic [4:0]                soc_cfg_add_o,
    output logic [31:0]               soc_cfg_data_o,
    input  logic [31:0]               soc_cfg_r_data_i,
    output logic                      soc_cfg_wrn_o,
    input  logic                      soc_cfg_lock_i,

    output logic                      per_cfg_req_o,
    input  logic                      per_cfg_ack_i,
    output logic [4:0]                per_cfg_add_o,
    output logic [31:0]               per_cfg_data_o,
    input  logic [31:0]               per_cfg_r_data_i,
    output logic                      per_cfg_wrn_o,
    input  logic                      per_cfg_lock_i,

    output logic                      cluster_cfg_req_o,
    input  logic                      cluster_cfg_ack_i,
    output logic [4:0]                cluster_cfg_add_o,
    output logic [31:0]               cluster_cfg_data_o,
    input  logic [31:0]               cluster_cfg_r_data_i,
    output logic                      cluster_cfg_wrn_o,
    input  logic                      cluster_cfg_lock_i,

    output logic                      lock_lost_irq_o
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (APB_ADDR_WIDTH < 10) begin : g_bad_addr
        $error("APB_ADDR_WIDTH must be at least 10");
    end

    state_e                  state_q;
    state_e                  state_d;
    channel_e                target;
    logic                    access;
    logic                    ch_start;
    logic                    st_access;
    logic                    st_write;
    logic                    sel_ack;
    logic                    to_hit;
    logic [NUM_CH-1:0]       req_q;
    logic [NUM_CH-1:0]       ack_vec;
    logic [NUM_CH-1:0]       lock_async;
    logic [NUM_CH-1:0]       lock_sync;
    logic [NUM_CH-1:0]       lost;
    logic [NUM_CH-1:0]       lost_clr;
    logic [CFG_ADD_W-1:0]    add_q;
    logic [CFG_DATA_W-1:0]   data_q;
    logic [CFG_DATA_W-1:0]   rdata_sel;
    logic [CFG_DATA_W-1:0]   prdata_q;
    logic                    wrn_q;
    logic                    irq_q;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{paddr_i[APB_ADDR_WIDTH-1:9], paddr_i[1:0]};

    assign target    = channel_e'(paddr_i[8:7]);
    assign access    = psel_i & penable_i;
    assign ch_start  = (state_q == ST_IDLE) & access & (target != CH_STATUS);
    assign st_access = (state_q == ST_IDLE) & access & (target == CH_STATUS);
    assign st_write  = st_access & pwrite_i;

    assign ack_vec    = {cluster_cfg_ack_i, per_cfg_ack_i, soc_cfg_ack_i};
    assign lock_async = {cluster_cfg_lock_i, per_cfg_lock_i, soc_cfg_lock_i};
    assign sel_ack    = |(req_q & ack_vec);

    // req_q is one-hot while a handshake is open, so it doubles as read mux select.
    assign rdata_sel = ({CFG_DATA_W{req_q[0]}} & soc_cfg_r_data_i)
                     | ({CFG_DATA_W{req_q[1]}} & per_cfg_r_data_i)
                     | ({CFG_DATA_W{req_q[2]}} & cluster_cfg_r_data_i);

`ifdef CLK_CFG_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    assign to_hit = (state_q == ST_REQ) & ~sel_ack
                  & (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state_q == ST_REQ) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_q <= '0;
            end
            if (to_hit) begin
                err_q <= 1'b1;
            end else if (state_q == ST_RESP) begin
                err_q <= 1'b0;
            end
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ch_start)          state_d = ST_REQ;
            ST_REQ:  if (sel_ack || to_hit) state_d = ST_RESP;
            ST_RESP:                        state_d = ST_IDLE;
            default:                        state_d = ST_IDLE;
        endcase
    end

    // A master that dropped psel mid-transfer gets no response.
    always_comb begin
        pready_o  = 1'b0;
        pslverr_o = 1'b0;
        prdata_o  = '0;
        case (state_q)
            ST_IDLE: begin
                if (st_access) begin
                    pready_o = 1'b1;
                    if (!pwrite_i) begin
                        prdata_o = status_word(lock_sync, lost);
                    end
                end
            end
            ST_RESP: begin
                if (access) begin
                    pready_o = 1'b1;
                    prdata_o = prdata_q;
`ifdef CLK_CFG_TIMEOUT_EN
                    pslverr_o = err_q;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            add_q    <= '0;
            data_q   <= '0;
            wrn_q    <= 1'b0;
            req_q    <= '0;
            prdata_q <= '0;
        end else begin
            if (ch_start) begin
                add_q  <= paddr_i[6:2];
                data_q <= pwdata_i;
                wrn_q  <= ~pwrite_i;
                req_q  <= {{(NUM_CH-1){1'b0}}, 1'b1} << target;
            end else if ((state_q == ST_REQ) && (sel_ack || to_hit)) begin
                req_q    <= '0;
                prdata_q <= (sel_ack && wrn_q) ? rdata_sel : '0;
            end else if (state_q == ST_RESP) begin
                prdata_q <= '0;
            end
        end
    end

    assign lost_clr = st_write ? pwdata_i[STATUS_LOST_LSB +: NUM_CH] : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lock
        clk_cfg_lock_mon u_mon (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .lock_async (lock_async[i]),
            .clr        (lost_clr[i]),
            .lock_sync  (lock_sync[i]),
            .lost       (lost[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |lost;
        end
    end

    assign lock_lost_irq_o = irq_q;

    assign soc_cfg_req_o      = req_q[0];
    assign per_cfg_req_o      = req_q[1];
    assign cluster_cfg_req_o  = req_q[2];

    assign soc_cfg_add_o      = add_q;
    assign per_cfg_add_o      = add_q;
    assign cluster_cfg_add_o  = add_q;

    assign soc_cfg_data_o     = data_q;
    assign per_cfg_data_o     = data_q;
    assign cluster_cfg_data_o = data_q;

    assign soc_cfg_wrn_o      = wrn_q;
    assign per_cfg_wrn_o      = wrn_q;
    assign cluster_cfg_wrn_o  = wrn_q;

endmodule

// File: tb/tb_apb_clk_cfg_if.sv
// Bench for apb_clk_cfg_if: directed and randomized APB accesses against a
// transaction-level expectation of latency, handshake and status contents.
module tb_apb_clk_cfg_if;

    logic        clk;
    logic        rst_n;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        irq;

    logic [2:0]  req;
    logic [2:0]  ack;
    logic [2:0]  lock;
    logic [2:0]  wrn_o;
    logic [4:0]  add_o  [3];
    logic [31:0] data_o [3];
    logic [31:0] rdata  [3];

    int          ack_delay [3];
    int          req_cnt   [3];

    int          n_checks;
    int          n_errors;

    logic [31:0] x_rdata;
    logic        x_err;
    logic        x_done;
    int          x_lat;
    int          x_req_cyc [3];
    logic [2:0]  exp_lost;

    apb_clk_cfg_if #(
        .APB_ADDR_WIDTH (12),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .paddr_i              (paddr),
        .pwdata_i             (pwdata),
        .pwrite_i             (pwrite),
        .psel_i               (psel),
        .penable_i            (penable),
        .prdata_o             (prdata),
        .pready_o             (pready),
        .pslverr_o            (pslverr),
        .soc_cfg_req_o        (req[0]),
        .soc_cfg_ack_i        (ack[0]),
        .soc_cfg_add_o        (add_o[0]),
        .soc_cfg_data_o       (data_o[0]),
        .soc_cfg_r_data_i     (rdata[0]),
        .soc_cfg_wrn_o        (wrn_o[0]),
        .soc_cfg_lock_i       (lock[0]),
        .per_cfg_req_o        (req[1]),
        .per_cfg_ack_i        (ack[1]),
        .per_cfg_add_o        (add_o[1]),
        .per_cfg_data_o       (data_o[1]),
        .per_cfg_r_data_i     (rdata[1]),
        .per_cfg_wrn_o        (wrn_o[1]),
        .per_cfg_lock_i       (lock[1]),
        .cluster_cfg_req_o    (req[2]),
        .cluster_cfg_ack_i    (ack[2]),
        .cluster_cfg_add_o    (add_o[2]),
        .cluster_cfg_data_o   (data_o[2]),
        .cluster_cfg_r_data_i (rdata[2]),
        .cluster_cfg_wrn_o    (wrn_o[2]),
        .cluster_cfg_lock_i   (lock[2]),
        .lock_lost_irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel responder: ack rises after req has been high ack_delay cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            req_cnt[i] <= req[i] ? req_cnt[i] + 1 : 0;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            ack[i] = req[i] && (req_cnt[i] >= ack_delay[i]);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w = '0;
        w[2:0]  = lock;
        w[10:8] = exp_lost;
        return w;
    endfunction

    // Call at #1 after a rising edge; returns at #1 after the completing edge.
    task automatic apb_xfer(input logic [11:0] a, input logic [31:0] d, input logic wr);
        paddr   = a;
        pwdata  = d;
        pwrite  = wr;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable   = 1'b1;
        x_lat     = 0;
        x_done    = 1'b0;
        x_rdata   = '0;
        x_err     = 1'b0;
        x_req_cyc = '{0, 0, 0};
        while (!x_done && x_lat < 400) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (req[i]) x_req_cyc[i]++;
            if (pready) begin
                x_done  = 1'b1;
                x_rdata = prdata;
                x_err   = pslverr;
            end else begin
                x_lat++;
            end
            @(posedge clk); #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        if (!x_done) check("xfer_no_pready", 32'd0, 32'd1);
    endtask

    task automatic chan_xfer(input logic [11:0] a, input logic wr, input int dly,
                             input logic [31:0] wd, input logic [31:0] rd);
        int tgt;
        int others;
        tgt = int'(a[8:7]);
        for (int i = 0; i < 3; i++) rdata[i] = $urandom;
        rdata[tgt]     = rd;
        ack_delay[tgt] = dly;
        apb_xfer(a, wd, wr);
        others = 0;
        for (int i = 0; i < 3; i++) if (i != tgt) others += x_req_cyc[i];
        check("ch_latency",  32'(x_lat), 32'(dly + 2));
        check("ch_req_cyc",  32'(x_req_cyc[tgt]), 32'(dly + 1));
        check("ch_other_req", 32'(others), 32'd0);
        check("ch_add",      32'(add_o[tgt]), 32'(a[6:2]));
        check("ch_data",     data_o[tgt], wd);
        check("ch_wrn",      32'(wrn_o[tgt]), 32'(!wr));
        check("ch_prdata",   x_rdata, wr ? 32'd0 : rd);
        check("ch_pslverr",  32'(x_err), 32'd0);
    endtask

    task automatic status_read(input string tag);
        apb_xfer(12'h180, 32'd0, 1'b0);
        check(tag, x_rdata, exp_status());
        check("st_latency", 32'(x_lat), 32'd0);
    endtask

    task automatic idle_check_irq(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
        check("irq", 32'(irq), 32'(|exp_lost));
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] pw;
        logic        wr;
        logic        seen;
        int          c;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        lock     = 3'b111;
        exp_lost = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ack_delay[i] = 0;
            rdata[i]     = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl",   {27'd0, pready, pslverr, irq, req}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_wrn",    32'(wrn_o), 32'd0);
        check("rst_add",    32'(add_o[0]), 32'd0);
        check("rst_data",   data_o[2], 32'd0);

        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        status_read("st_after_rst");

        // soc read, ack same cycle as req
        chan_xfer(12'h008, 1'b0, 0, 32'h0, 32'h0001_0003);
        // cluster write, ack 5 cycles late
        chan_xfer(12'h104, 1'b1, 5, 32'hA5A5_0001, 32'h1234_5678);

        // per lock loss, clear, then clear coinciding with a new fall
        lock[1] = 1'b0;
        exp_lost[1] = 1'b1;
        idle_check_irq(5);
        status_read("st_per_lost");
        apb_xfer(12'h180, 32'h0000_0200, 1'b1);
        check("st_w1c_prdata", x_rdata, 32'd0);
        exp_lost[1] = 1'b0;
        idle_check_irq(2);
        status_read("st_per_cleared");
        lock[1] = 1'b1;
        idle_check_irq(5);
        status_read("st_rise_no_set");

        lock[1] = 1'b0;
        @(posedge clk); #1;
        paddr   = 12'h180;
        pwdata  = 32'h0000_0200;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        exp_lost[1] = 1'b1;
        idle_check_irq(3);
        status_read("st_set_wins");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                c = $urandom_range(0, 2);
                lock[c] = ~lock[c];
                if (!lock[c]) exp_lost[c] = 1'b1;
                idle_check_irq(5);
            end
            wr = 1'($urandom_range(0, 1));
            pw = $urandom;
            a  = 12'($urandom);
            if ($urandom_range(0, 3) == 3) begin
                a[8:7] = 2'd3;
                apb_xfer(a, pw, wr);
                check("rnd_st_latency", 32'(x_lat), 32'd0);
                if (wr) begin
                    check("rnd_st_wr_prdata", x_rdata, 32'd0);
                    exp_lost = exp_lost & ~pw[10:8];
                end else begin
                    check("rnd_st_rd", x_rdata, exp_status());
                end
            end else begin
                a[8:7] = 2'($urandom_range(0, 2));
                chan_xfer(a, wr, $urandom_range(0, 6), pw, $urandom);
            end
            idle_check_irq(2);
        end

`ifdef CLK_CFG_TIMEOUT_EN
        ack_delay[0] = 100000;
        rdata[0]     = 32'hDEAD_BEEF;
        apb_xfer(12'h008, 32'd0, 1'b0);
        check("to_req_cyc", 32'(x_req_cyc[0]), 32'd256);
        check("to_pslverr", 32'(x_err), 32'd1);
        check("to_prdata",  x_rdata, 32'd0);
        check("to_latency", 32'(x_lat), 32'd257);
        @(posedge clk); #1;
        chan_xfer(12'h00C, 1'b0, 1, 32'd0, 32'hCAFE_0042);
`endif

        // reset while a handshake is open
        @(posedge clk); #1;
        ack_delay[0] = 1000;
        paddr   = 12'h010;
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = req[0];
        end
        check("rst_req_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", 32'(req), 32'd0);
        psel    = 1'b0;
        penable = 1'b0;
        exp_lost = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ack_delay[0] = 0;
        repeat (4) @(posedge clk);
        #1;
        chan_xfer(12'h008, 1'b0, 0, 32'd0, 32'h0001_0003);
        status_read("st_after_mid_rst");
        idle_check_irq(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
